// File: rtl/ins_mem_responder.sv
// Byte-wide dual-port instruction fetch memory with a word loader.
// The loader writes one byte per cycle, so each word takes four WRITE cycles.
module ins_mem_responder #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_low,
   input  logic [31:0] addr_high,
   output logic [7:0]  ins_low,
   output logic [7:0]  ins_high,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        busy,
   output logic [15:0] ld_count
);

   localparam int WORDS = MEM_BYTES / 4;

   typedef enum logic {
      IDLE,
      WRITE
   } state_e;

   // Word-organised storage so the NOP image is a single default fill.
   logic [31:0] mem [WORDS] = '{default: 32'h0000_0013};

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       data_q, data_d;
   logic [15:0]       count_q, count_d;
   logic [7:0]        ins_low_q, ins_low_d;
   logic [7:0]        ins_high_q, ins_high_d;

   logic              wr_en;
   logic [ADDR_W-3:0] wr_idx;
   logic [7:0]        wr_byte;

   logic [ADDR_W-3:0] lo_idx, hi_idx;
   logic [31:0]       lo_word, hi_word;
   logic              unused;

   assign lo_idx  = addr_low[ADDR_W-1:2];
   assign hi_idx  = addr_high[ADDR_W-1:2];
   assign lo_word = mem[lo_idx];
   assign hi_word = mem[hi_idx];

   always_comb begin
      ins_low_d  = lo_word[{addr_low[1:0], 3'b000} +: 8];
      ins_high_d = hi_word[{addr_high[1:0], 3'b000} +: 8];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      data_d  = data_q;
      count_d = count_q;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ld_valid) begin
               state_d = WRITE;
               base_d  = {ld_addr[ADDR_W-1:2], 2'b00};
               data_d  = ld_data;
               cnt_d   = 2'd0;
            end
         end
         WRITE: begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = IDLE;
               count_d = count_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_idx  = base_q[ADDR_W-1:2];
   assign wr_byte = data_q[{cnt_q, 3'b000} +: 8];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         base_q     <= '0;
         data_q     <= '0;
         count_q    <= 16'd0;
         ins_low_q  <= 8'd0;
         ins_high_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         data_q     <= data_d;
         count_q    <= count_d;
         ins_low_q  <= ins_low_d;
         ins_high_q <= ins_high_d;
      end
   end

   // Storage has no reset; reads above see the pre-write value on collision.
   always_ff @(posedge clk) begin
      if (wr_en && rst) begin
         mem[wr_idx][{cnt_q, 3'b000} +: 8] <= wr_byte;
      end
   end

   assign ins_low  = ins_low_q;
   assign ins_high = ins_high_q;
   assign ld_ready = (state_q == IDLE) && rst;
   assign busy     = (state_q == WRITE);
   assign ld_count = count_q;

   assign unused = ^{addr_low[31:ADDR_W], addr_high[31:ADDR_W],
                     ld_addr[31:ADDR_W], ld_addr[1:0], base_q[1:0]};

endmodule
